wavetable_ram_arbiter: RTL and testbench
========================================

WAVETABLE_RAM_ARBITER -- requirements
Module: wavetable_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, RAM data width; byte-enable width is DATA_W/8.
REQ-003 SHALL have parameter STARVE_MAX, default 4, range 1-15: consecutive host-losing cycles before the host is forced a slot.
REQ-004 SHALL use one clock and a synchronous, active-high reset:
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high
REQ-005 SHALL have the following host (Avalon-MM slave) ports:
  h_address  in  ADDR_W  word address
  h_byteenable  in  DATA_W/8  write byte lanes
  h_read  in  1  read request
  h_write  in  1  write request
  h_writedata  in  DATA_W  write data
  h_waitrequest  out  1  request not accepted this cycle
  h_readdata  out  DATA_W  read data
  h_readdatavalid  out  1  h_readdata valid
REQ-006 SHALL have the following DDS wavetable read ports:
  d_req  in  1  sample fetch request
  d_address  in  ADDR_W  table index
  d_gnt  out  1  fetch accepted this cycle
  d_readdata  out  DATA_W  sample
  d_valid  out  1  d_readdata valid
REQ-007 SHALL have the following single-port RAM master ports:
  m_address  out  ADDR_W
  m_byteenable  out  DATA_W/8
  m_chipselect  out  1  access issued this cycle
  m_write  out  1
  m_writedata  out  DATA_W
  m_clken  out  1
  m_readdata  in  DATA_W  valid one cycle after a read issue

Function
REQ-008 SHALL issue at most one RAM access per cycle; m_chipselect=1 exactly in issue cycles.
REQ-009 SHALL drive m_clken=1 constantly.
REQ-010 SHALL grant DDS when d_req=1 and no forced host slot: d_gnt=1, m_address=d_address, m_write=0, m_byteenable all ones.
REQ-011 SHALL grant the host when (h_read|h_write)=1 and the DDS is not granted: h_waitrequest=0, m_address=h_address, m_write=h_write, m_byteenable=h_byteenable, m_writedata=h_writedata.
REQ-012 SHALL drive h_waitrequest=(h_read|h_write) & ~host_grant, combinationally, in every non-reset cycle.
REQ-013 SHALL treat h_read=h_write=1 as a write, with no read return.
REQ-014 SHALL register a 2-bit return tag {host_rd, dds_rd} at each read issue; the next cycle it asserts exactly one of h_readdatavalid/d_valid, with m_readdata routed to that port's readdata; fixed latency is 1 cycle.
REQ-015 SHALL keep each readdata output holding its last returned value when its valid flag is 0.
REQ-016 SHALL sustain back-to-back reads, one per cycle, from either requester with no bubble.
REQ-017 SHALL implement a starvation counter starve_cnt (4 bits): +1 in each cycle the host requests and loses to DDS; cleared on a host grant or when the host is idle; saturating at STARVE_MAX.
REQ-018 SHALL force the host slot when starve_cnt==STARVE_MAX and the host is requesting: host granted, d_gnt=0 even with d_req=1, and starve_cnt cleared.
REQ-019 SHALL require no hold of d_req/d_address by the arbiter; a DDS request with d_gnt=0 is retried by the requester.

Reset
REQ-020 SHALL, while reset=1: m_chipselect=0, m_write=0, d_gnt=0, h_waitrequest=1, h_readdatavalid=0, d_valid=0.
REQ-021 SHALL clear starve_cnt, the return tag, h_readdata and d_readdata to 0 on a clock edge with reset=1.
REQ-022 SHALL discard a read issued in the cycle before reset rises: no valid is produced after reset.
REQ-023 SHALL make the first grant possible in the first cycle after reset falls.

Configuration
REQ-024 SHALL compile the starvation guard (REQ-017, REQ-018) only when macro WTARB_STARVE_GUARD_EN is defined.
REQ-025 SHALL, without WTARB_STARVE_GUARD_EN, use strict DDS priority with no counter; the host waits indefinitely while d_req=1.

Verification
REQ-026 SHALL cover: host write addr 0x005, be=2'b11, data 0xA5A5, then host read 0x005 -> h_readdatavalid one cycle after issue, h_readdata=0xA5A5.
REQ-027 SHALL cover: host write be=2'b01 data 0x1234 onto stored 0xA5A5 -> readback 0xA534.
REQ-028 SHALL cover: d_req held 10 cycles with host read pending, guard enabled, STARVE_MAX=4 -> host granted in cycle 5 with d_gnt=0 that cycle; guard disabled -> host granted only after d_req drops.
REQ-029 SHALL cover: alternating DDS/host reads every cycle -> valids alternate and each readdata matches its own address, no cross-routing.
REQ-030 SHALL cover: reset asserted the cycle after a DDS read issue -> d_valid stays 0; all outputs match REQ-020; normal grant resumes in the first post-reset cycle.

Source files
------------

// File: rtl/wavetable_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wavetable_ram_arbiter
// Description : Shares one single-port RAM between an Avalon-MM host and a DDS
//               wavetable reader. DDS wins by default. The optional host
//               starvation guard is enabled by defining WTARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wavetable_ram_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    // host (Avalon-MM slave)
    input  logic [ADDR_W-1:0]     h_address,
    input  logic [DATA_W/8-1:0]   h_byteenable,
    input  logic                  h_read,
    input  logic                  h_write,
    input  logic [DATA_W-1:0]     h_writedata,
    output logic                  h_waitrequest,
    output logic [DATA_W-1:0]     h_readdata,
    output logic                  h_readdatavalid,
    // DDS wavetable reader
    input  logic                  d_req,
    input  logic [ADDR_W-1:0]     d_address,
    output logic                  d_gnt,
    output logic [DATA_W-1:0]     d_readdata,
    output logic                  d_valid,
    // single-port RAM master
    output logic [ADDR_W-1:0]     m_address,
    output logic [DATA_W/8-1:0]   m_byteenable,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic [DATA_W-1:0]     m_writedata,
    output logic                  m_clken,
    input  logic [DATA_W-1:0]     m_readdata
);

    localparam int C_BE_W = DATA_W / 8;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_max_range
        $error("STARVE_MAX must lie in 1..15");
    end

    logic                w_host_req;
    logic                w_force_host;
    logic                w_dds_gnt;
    logic                w_host_gnt;
    logic [1:0]          tag_q;
    logic [1:0]          tag_d;
    logic [DATA_W-1:0]   h_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    assign w_host_req = h_read | h_write;

`ifdef WTARB_STARVE_GUARD_EN
    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    assign w_force_host = w_host_req && (starve_cnt_q == C_STARVE_MAX);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (w_host_gnt || !w_host_req) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != C_STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign w_force_host = 1'b0;
`endif

    // Grants are qualified by reset so nothing reaches the RAM while it is held.
    assign w_dds_gnt  = ~reset & d_req & ~w_force_host;
    assign w_host_gnt = ~reset & w_host_req & ~w_dds_gnt;

    assign d_gnt         = w_dds_gnt;
    assign h_waitrequest = reset | (w_host_req & ~w_host_gnt);

    assign m_clken      = 1'b1;
    assign m_chipselect = w_dds_gnt | w_host_gnt;
    assign m_write      = w_host_gnt & h_write;
    assign m_address    = w_dds_gnt ? d_address : h_address;
    assign m_byteenable = w_dds_gnt ? {C_BE_W{1'b1}} : h_byteenable;
    assign m_writedata  = h_writedata;

    // A simultaneous read+write is a write, so it never produces a return.
    assign tag_d = {w_host_gnt & h_read & ~h_write, w_dds_gnt};

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q     <= 2'b00;
            h_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            tag_q <= tag_d;
            if (tag_q[1]) begin
                h_rdata_q <= m_readdata;
            end
            if (tag_q[0]) begin
                d_rdata_q <= m_readdata;
            end
        end
    end

    // A tag left over from the cycle before reset must not surface as a valid.
    assign h_readdatavalid = ~reset & tag_q[1];
    assign d_valid         = ~reset & tag_q[0];
    assign h_readdata      = h_readdatavalid ? m_readdata : h_rdata_q;
    assign d_readdata      = d_valid ? m_readdata : d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wavetable_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wavetable_ram_arbiter
// Description : Self-checking bench for wavetable_ram_arbiter with a RAM model,
//               a behavioural reference and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wavetable_ram_arbiter;

    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 16;
    localparam int BE_W       = 2;
    localparam int STARVE_MAX = 4;
`ifdef WTARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] h_address = '0;
    logic [BE_W-1:0]   h_byteenable = '0;
    logic              h_read = 1'b0;
    logic              h_write = 1'b0;
    logic [DATA_W-1:0] h_writedata = '0;
    logic              h_waitrequest;
    logic [DATA_W-1:0] h_readdata;
    logic              h_readdatavalid;
    logic              d_req = 1'b0;
    logic [ADDR_W-1:0] d_address = '0;
    logic              d_gnt;
    logic [DATA_W-1:0] d_readdata;
    logic              d_valid;
    logic [ADDR_W-1:0] m_address;
    logic [BE_W-1:0]   m_byteenable;
    logic              m_chipselect;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic              m_clken;
    logic [DATA_W-1:0] m_readdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    wavetable_ram_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .h_address       (h_address),
        .h_byteenable    (h_byteenable),
        .h_read          (h_read),
        .h_write         (h_write),
        .h_writedata     (h_writedata),
        .h_waitrequest   (h_waitrequest),
        .h_readdata      (h_readdata),
        .h_readdatavalid (h_readdatavalid),
        .d_req           (d_req),
        .d_address       (d_address),
        .d_gnt           (d_gnt),
        .d_readdata      (d_readdata),
        .d_valid         (d_valid),
        .m_address       (m_address),
        .m_byteenable    (m_byteenable),
        .m_chipselect    (m_chipselect),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_clken         (m_clken),
        .m_readdata      (m_readdata)
    );

    always #5 clk = ~clk;

    // Power-on pattern of every RAM word, shared by the RAM model and reference.
    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return ({5'b0, a} * 16'h0101) ^ 16'h5A00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM environment: one-cycle read latency, byte-lane writes.
    logic [DATA_W-1:0] ram [2**ADDR_W];
    bit                ram_written [2**ADDR_W];

    always @(posedge clk) begin
        if (m_chipselect && m_clken) begin
            if (m_write) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (m_byteenable[b]) begin
                        ram[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
                    end else if (!ram_written[m_address]) begin
                        ram[m_address][8*b +: 8] <= init_word(m_address)[8*b +: 8];
                    end
                end
                ram_written[m_address] <= 1'b1;
            end else begin
                m_readdata <= ram_written[m_address] ? ram[m_address] : init_word(m_address);
            end
        end
    end

    // Reference model and per-cycle compare.
    initial begin : model
        logic [DATA_W-1:0] ref_mem [2**ADDR_W];
        int                losses;
        bit                pend_h, pend_d, hreq, force_h, dg, hg;
        logic [DATA_W-1:0] pend_hdata, pend_ddata, last_h, last_d;
        for (int a = 0; a < 2**ADDR_W; a++) ref_mem[a] = init_word(11'(a));
        losses = 0; pend_h = 0; pend_d = 0;
        pend_hdata = '0; pend_ddata = '0; last_h = '0; last_d = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_cs",     32'(m_chipselect),    32'(0));
                chk("rst_mwrite", 32'(m_write),         32'(0));
                chk("rst_dgnt",   32'(d_gnt),           32'(0));
                chk("rst_wait",   32'(h_waitrequest),   32'(1));
                chk("rst_hvalid", 32'(h_readdatavalid), 32'(0));
                chk("rst_dvalid", 32'(d_valid),         32'(0));
                losses = 0; pend_h = 0; pend_d = 0; last_h = '0; last_d = '0;
            end else begin
                hreq    = h_read | h_write;
                force_h = GUARD && hreq && (losses >= STARVE_MAX);
                dg      = d_req && !force_h;
                hg      = hreq && !dg;
                chk("dgnt",   32'(d_gnt),         32'(dg));
                chk("wait",   32'(h_waitrequest), 32'(hreq && !hg));
                chk("cs",     32'(m_chipselect),  32'(dg || hg));
                chk("clken",  32'(m_clken),       32'(1));
                if (dg) begin
                    chk("m_addr_d", 32'(m_address),    32'(d_address));
                    chk("m_wr_d",   32'(m_write),      32'(0));
                    chk("m_be_d",   32'(m_byteenable), 32'(2'b11));
                end
                if (hg) begin
                    chk("m_addr_h", 32'(m_address),    32'(h_address));
                    chk("m_wr_h",   32'(m_write),      32'(h_write));
                    chk("m_be_h",   32'(m_byteenable), 32'(h_byteenable));
                    chk("m_wd_h",   32'(m_writedata),  32'(h_writedata));
                end
                chk("hvalid", 32'(h_readdatavalid), 32'(pend_h));
                chk("dvalid", 32'(d_valid),         32'(pend_d));
                chk("hdata",  32'(h_readdata), 32'(pend_h ? pend_hdata : last_h));
                chk("ddata",  32'(d_readdata), 32'(pend_d ? pend_ddata : last_d));
                if (pend_h) last_h = pend_hdata;
                if (pend_d) last_d = pend_ddata;
                pend_h     = hg && h_read && !h_write;
                pend_hdata = ref_mem[h_address];
                pend_d     = dg;
                pend_ddata = ref_mem[d_address];
                if (hg && h_write) begin
                    for (int b = 0; b < BE_W; b++)
                        if (h_byteenable[b]) ref_mem[h_address][8*b +: 8] = h_writedata[8*b +: 8];
                end
                losses = (hg || !hreq) ? 0 : (losses < 15 ? losses + 1 : 15);
            end
        end
    end

    task automatic drive(input logic rst, input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] be,
                         input logic [DATA_W-1:0] wd, input logic dr,
                         input logic [ADDR_W-1:0] da);
        @(posedge clk);
        #1;
        reset = rst; h_read = rd; h_write = wr; h_address = a;
        h_byteenable = be; h_writedata = wd; d_req = dr; d_address = da;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, 2'b11, '0, 1'b0, '0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int granted_at;
        logic gnt_d;
        drive(1'b1, 1'b0, 1'b0, '0, 2'b11, '0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, 2'b11, '0, 1'b0, '0);

        // Full write, readback one cycle after issue.
        drive(1'b0, 1'b0, 1'b1, 11'h005, 2'b11, 16'hA5A5, 1'b0, '0);
        @(negedge clk);
        chk("lit_wr_accept", 32'(h_waitrequest), 32'(0));
        drive(1'b0, 1'b1, 1'b0, 11'h005, 2'b11, '0, 1'b0, '0);
        idle();
        @(negedge clk);
        chk("lit_rd_valid", 32'(h_readdatavalid), 32'(1));
        chk("lit_rd_A5A5",  32'(h_readdata),      32'(16'hA5A5));

        // Low-lane-only write merges with stored data.
        drive(1'b0, 1'b0, 1'b1, 11'h005, 2'b01, 16'h1234, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b0, 11'h005, 2'b11, '0, 1'b0, '0);
        idle();
        @(negedge clk);
        chk("lit_rd_A534", 32'(h_readdata), 32'(16'hA534));

        // Read and write together behave as a write with no return.
        drive(1'b0, 1'b1, 1'b1, 11'h006, 2'b11, 16'hBEEF, 1'b0, '0);
        idle();
        @(negedge clk);
        chk("lit_rw_novalid", 32'(h_readdatavalid), 32'(0));
        drive(1'b0, 1'b1, 1'b0, 11'h006, 2'b11, '0, 1'b0, '0);
        idle();
        @(negedge clk);
        chk("lit_rd_BEEF", 32'(h_readdata), 32'(16'hBEEF));

        // DDS held for 10 cycles against a pending host read.
        granted_at = 0;
        gnt_d = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            drive(1'b0, granted_at == 0, 1'b0, 11'h020, 2'b11, '0, c <= 10, 11'(c));
            @(negedge clk);
            if (granted_at == 0 && !h_waitrequest) begin
                granted_at = c;
                gnt_d = d_gnt;
            end
        end
        chk("lit_starve_cycle", 32'(granted_at), GUARD ? 32'(5) : 32'(11));
        chk("lit_starve_dgnt",  32'(gnt_d),      32'(0));

        // Alternating DDS / host reads, one per cycle.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(1'b0, 1'b0, 1'b0, '0, 2'b11, '0, 1'b1, 11'(11'h040 + i));
            else            drive(1'b0, 1'b1, 1'b0, 11'(11'h060 + i), 2'b11, '0, 1'b0, '0);
            @(negedge clk);
            if (i == 1) begin
                chk("lit_alt_dvalid", 32'(d_valid),         32'(1));
                chk("lit_alt_d1A40",  32'(d_readdata),      32'(16'h1A40));
                chk("lit_alt_hquiet", 32'(h_readdatavalid), 32'(0));
            end
            if (i == 2) begin
                chk("lit_alt_hvalid", 32'(h_readdatavalid), 32'(1));
                chk("lit_alt_h3B61",  32'(h_readdata),      32'(16'h3B61));
                chk("lit_alt_dquiet", 32'(d_valid),         32'(0));
            end
        end
        idle();

        // Reset lands the cycle after a DDS read issue.
        drive(1'b0, 1'b0, 1'b0, '0, 2'b11, '0, 1'b1, 11'h007);
        @(negedge clk);
        chk("lit_pre_rst_dgnt", 32'(d_gnt), 32'(1));
        drive(1'b1, 1'b1, 1'b0, 11'h003, 2'b11, '0, 1'b1, 11'h007);
        @(negedge clk);
        chk("lit_rst_dvalid", 32'(d_valid),       32'(0));
        chk("lit_rst_dgnt",   32'(d_gnt),         32'(0));
        chk("lit_rst_cs",     32'(m_chipselect),  32'(0));
        chk("lit_rst_wait",   32'(h_waitrequest), 32'(1));
        drive(1'b1, 1'b1, 1'b0, 11'h003, 2'b11, '0, 1'b1, 11'h007);
        drive(1'b0, 1'b0, 1'b0, '0, 2'b11, '0, 1'b1, 11'h009);
        @(negedge clk);
        chk("lit_post_rst_dgnt",  32'(d_gnt),      32'(1));
        chk("lit_post_rst_dval",  32'(d_valid),    32'(0));
        chk("lit_post_rst_ddata", 32'(d_readdata), 32'(0));
        idle();
        @(negedge clk);
        chk("lit_post_rst_dvalid2", 32'(d_valid),    32'(1));
        chk("lit_post_rst_d5309",   32'(d_readdata), 32'(16'h5309));
        idle();
        idle();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
